// File: rtl/div4_restoring_seq.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Drives an external N+1-bit adder with the shifted partial remainder and the
// inverted divisor (carry-in high) so that the adder performs a trial subtraction;
// the adder's carry-out selects commit vs. restore.
module div4_restoring_seq #(
   parameter int unsigned N = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [N-1:0] i_dividend,
   input  logic [N-1:0] i_divisor,
   output logic [N:0]   o_add_a,
   output logic [N:0]   o_add_b,
   output logic         o_add_cin,
   input  logic [N:0]   i_add_sum,
   input  logic         i_add_cout,
   output logic         o_busy,
   output logic         o_done,
   output logic [N-1:0] o_quotient,
   output logic [N-1:0] o_remainder,
   output logic         o_div_by_zero
);

   // Adder width is tied to the operand width.
   localparam int unsigned W  = N + 1;
   localparam int unsigned CW = $clog2(N) + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ITER = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]    r_state;
   logic [CW-1:0] r_count;
   logic [N-1:0]  r_r;
   logic [N-1:0]  r_q;
   logic [N-1:0]  r_d;
   logic [N-1:0]  r_quotient;
   logic [N-1:0]  r_remainder;
   logic          r_dbz;

   logic [N-1:0]  w_r_shift;
   logic [N-1:0]  w_r_iter;
   logic [N-1:0]  w_q_iter;
   logic          w_last;

   // Trial-subtraction operands and per-iteration next values of R and Q.
   always_comb begin
      o_add_a   = {r_r, r_q[N-1]};
      o_add_b   = ~{1'b0, r_d};
      o_add_cin = 1'b1;
      w_r_shift = {r_r[N-2:0], r_q[N-1]};
      // R < D keeps the shifted remainder within W bits, so sum[W-1] is unused.
      w_r_iter  = i_add_cout ? i_add_sum[N-1:0] : w_r_shift;
      w_q_iter  = {r_q[N-2:0], i_add_cout};
      w_last    = (r_count == CW'(N - 1));
   end

   // State machine, datapath registers and held results.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_r         <= '0;
         r_q         <= '0;
         r_d         <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_d     <= i_divisor;
                  r_q     <= i_dividend;
                  r_r     <= '0;
                  r_count <= '0;
                  if (i_divisor == '0) begin
                     // No iterations: report all-ones quotient and pass dividend through.
                     r_state     <= ST_DONE;
                     r_quotient  <= '1;
                     r_remainder <= i_dividend;
                     r_dbz       <= 1'b1;
                  end else begin
                     r_state <= ST_ITER;
                  end
               end
            end
            ST_ITER: begin
               r_r     <= w_r_iter;
               r_q     <= w_q_iter;
               r_count <= r_count + 1'b1;
               if (w_last) begin
                  r_state     <= ST_DONE;
                  r_quotient  <= w_q_iter;
                  r_remainder <= w_r_iter;
                  r_dbz       <= 1'b0;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Status and result outputs.
   always_comb begin
      o_busy        = (r_state != ST_IDLE);
      o_done        = (r_state == ST_DONE);
      o_quotient    = r_quotient;
      o_remainder   = r_remainder;
      o_div_by_zero = r_dbz;
   end

   // W is documented as the adder width; referenced here to keep it tied to ports.
   logic [W-1:0] w_unused_sum_msb;
   assign w_unused_sum_msb = i_add_sum;

endmodule

// File: tb/tb_div4_restoring_seq.sv
// Directed bench for div4_restoring_seq with a behavioural 5-bit adder attached.
module tb_div4_restoring_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] dividend;
   logic [3:0] divisor;
   logic [4:0] add_a;
   logic [4:0] add_b;
   logic       add_cin;
   logic [4:0] add_sum;
   logic       add_cout;
   logic       busy;
   logic       done;
   logic [3:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;

   int checks = 0;
   int errors = 0;

   // Expected held results from the previous operation.
   logic [3:0] hq = 4'd0;
   logic [3:0] hr = 4'd0;

   logic [5:0] tot;
   assign tot      = {1'b0, add_a} + {1'b0, add_b} + {5'd0, add_cin};
   assign add_sum  = tot[4:0];
   assign add_cout = tot[5];

   div4_restoring_seq #(.N(4)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_start       (start),
      .i_dividend    (dividend),
      .i_divisor     (divisor),
      .o_add_a       (add_a),
      .o_add_b       (add_b),
      .o_add_cin     (add_cin),
      .i_add_sum     (add_sum),
      .i_add_cout    (add_cout),
      .o_busy        (busy),
      .o_done        (done),
      .o_quotient    (quotient),
      .o_remainder   (remainder),
      .o_div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run one operation; lat = edges after the accept edge until done is seen.
   task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] eq, input logic [3:0] er, input logic ez,
                         input int elat);
      int lat;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = 4'hx;
      divisor  = 4'hx;
      lat      = 0;
      while (!done && lat < 20) begin
         check({tag, " busy"}, {31'd0, busy}, 32'd1);
         check({tag, " cin"}, {31'd0, add_cin}, 32'd1);
         check({tag, " add_b"}, {27'd0, add_b}, {27'd0, ~{1'b0, b}});
         check({tag, " held q"}, {28'd0, quotient}, {28'd0, hq});
         check({tag, " held r"}, {28'd0, remainder}, {28'd0, hr});
         tick();
         lat++;
      end
      check({tag, " latency"}, lat, elat);
      check({tag, " done busy"}, {31'd0, busy}, 32'd1);
      check({tag, " q"}, {28'd0, quotient}, {28'd0, eq});
      check({tag, " r"}, {28'd0, remainder}, {28'd0, er});
      check({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
      hq = eq;
      hr = er;
      tick();
      check({tag, " done pulse"}, {31'd0, done}, 32'd0);
      check({tag, " idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int lat;
      int ndone;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = 4'd0;
      divisor  = 4'd0;
      tick();
      tick();
      rst = 1'b0;
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst q", {28'd0, quotient}, 32'd0);
      check("rst r", {28'd0, remainder}, 32'd0);
      check("rst dbz", {31'd0, div_by_zero}, 32'd0);
      check("rst add_a", {27'd0, add_a}, 32'd0);
      check("rst add_b", {27'd0, add_b}, 32'h1F);
      check("rst cin", {31'd0, add_cin}, 32'd1);

      // Normal ops: done appears after edge t+N, i.e. 4 edges past the accept edge.
      run_op("13/4", 4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 4);
      run_op("15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4);
      run_op("15/15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 4);
      run_op("5/7", 4'd5, 4'd7, 4'd0, 4'd5, 1'b0, 4);
      // Divide by zero goes straight to DONE off the accept edge.
      run_op("9/0", 4'd9, 4'd0, 4'hF, 4'd9, 1'b1, 0);
      run_op("6/3", 4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 4);

      // start held high through the busy window: only 14/3 is computed.
      dividend = 4'd14;
      divisor  = 4'd3;
      start    = 1'b1;
      tick();
      dividend = 4'd7;
      divisor  = 4'd2;
      lat      = 0;
      ndone    = 0;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      check("hold latency", lat, 4);
      check("hold q", {28'd0, quotient}, 32'd4);
      check("hold r", {28'd0, remainder}, 32'd2);
      tick();
      check("hold busy drop", {31'd0, busy}, 32'd0);
      check("hold no 2nd done", {31'd0, done}, 32'd0);
      tick();
      check("hold reaccept", {31'd0, busy}, 32'd1);
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      check("hold2 latency", lat, 4);
      check("hold2 q", {28'd0, quotient}, 32'd3);
      check("hold2 r", {28'd0, remainder}, 32'd1);
      tick();
      hq = 4'd3;
      hr = 4'd1;

      // Reset at the 2nd ITER edge discards the operation.
      dividend = 4'd11;
      divisor  = 4'd2;
      start    = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid rst busy", {31'd0, busy}, 32'd0);
      check("mid rst q", {28'd0, quotient}, 32'd0);
      check("mid rst r", {28'd0, remainder}, 32'd0);
      check("mid rst dbz", {31'd0, div_by_zero}, 32'd0);
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         if (done) ndone++;
         tick();
      end
      check("mid rst no done", ndone, 0);
      check("mid rst still idle", {31'd0, busy}, 32'd0);
      hq = 4'd0;
      hr = 4'd0;
      run_op("11/2", 4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 4);

      // Exhaustive sweep against a reference model.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            if (b == 0)
               run_op($sformatf("ex %0d/%0d", a, b), 4'(a), 4'(b), 4'hF, 4'(a), 1'b1, 0);
            else
               run_op($sformatf("ex %0d/%0d", a, b), 4'(a), 4'(b), 4'(a / b), 4'(a % b),
                      1'b0, 4);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
